// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Width of a counter that must hold 0..width inclusive.
  function automatic int step_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_run_edge_detect.sv
// Registered rising-edge detector for the Run request.
module run_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic start_o
);

  logic run_q;

  // Resetting to 1 keeps a Run level held through reset from looking like an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_q <= 1'b1;
    end else begin
      run_q <= run_i;
    end
  end

  assign start_o = run_i & ~run_q;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for an N-bit shift-add multiplier (A/B shift pair plus X sign bit).
// Handshake: a rising Run edge in IDLE starts an operation; Busy covers START..last shift;
// Done then holds until Run is low, after which the FSM returns to IDLE.
module shift_add_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit COMBINE = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Run,
  input  logic                       ClearA_LoadB,
  input  logic                       M,
  input  logic                       Signed,
  output logic                       Clr_Ld,
  output logic                       ClrA,
  output logic                       Add,
  output logic                       Sub,
  output logic                       Shift,
  output logic                       Busy,
  output logic                       Done,
  output logic [step_w(WIDTH)-1:0]   Step,
  output state_t                     State_dbg
);

  localparam int SW = step_w(WIDTH);

  state_t        state_q;
  logic [SW-1:0] step_q;
  logic          signed_q;
  logic          start;
  logic          last;

  run_edge_detect u_run_edge (
    .clk_i   (Clk),
    .reset_i (Reset),
    .run_i   (Run),
    .start_o (start)
  );

  assign last = (step_q == SW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= START;
        end
        START: begin
          step_q   <= '0;
          signed_q <= Signed;
          state_q  <= COMBINE ? EXEC : ADD;
        end
        ADD: begin
          state_q <= SHIFT;
        end
        SHIFT: begin
          step_q  <= step_q + SW'(1);
          state_q <= last ? DONE : ADD;
        end
        EXEC: begin
          step_q  <= step_q + SW'(1);
          state_q <= last ? DONE : EXEC;
        end
        DONE: begin
          if (!Run) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Add/Sub are Mealy on M: the final signed step subtracts the multiplicand instead.
  always_comb begin
    Clr_Ld = 1'b0;
    ClrA   = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (state_q)
      IDLE:  Clr_Ld = ClearA_LoadB;
      START: begin
        ClrA = 1'b1;
        Busy = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        Add  = M & ~(last & signed_q);
        Sub  = M & last & signed_q;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
      end
      EXEC: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        Add   = M & ~(last & signed_q);
        Sub   = M & last & signed_q;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign Step      = step_q;
  assign State_dbg = state_q;

endmodule
